// File: rtl/instr_dcd_burst_if.sv
// SPI-bridge / register-file bundle for the burst instruction decoder.
// The decoder sits on the master modport; the bridge and register file sit on slave.
interface instr_dcd_burst_if #(
    parameter int ADDR_W     = 6,
    parameter int DATA_BYTES = 1
);
    localparam int DATA_W = 8 * DATA_BYTES;

    logic              cs_active;
    logic              byte_sync;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_write;
    logic [DATA_W-1:0] data_read;
    logic              frame_err;

    modport master (
        input  cs_active, byte_sync, data_in, data_read,
        output data_out, read, write, addr, data_write, frame_err
    );

    modport slave (
        output cs_active, byte_sync, data_in, data_read,
        input  data_out, read, write, addr, data_write, frame_err
    );
endinterface

// File: rtl/instr_dcd_burst.sv
// SPI instruction decoder: command phase (RW, INC, address), then DATA_BYTES-byte words
// turned into one-cycle register read/write strobes, with burst auto-increment.
module instr_dcd_burst #(
    parameter int ADDR_W     = 6,
    parameter int DATA_BYTES = 1
) (
    input logic               clk,
    input logic               rst,
    instr_dcd_burst_if.master bus
);
    localparam int CMD_BYTES = (ADDR_W + 2 + 7) / 8;
    localparam int DATA_W    = 8 * DATA_BYTES;

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RFETCH, RDATA, DONE} state_t;

    state_t            state;
    logic              rw;
    logic              inc;
    logic [5:0]        cmd_hi;
    logic [1:0]        cnt;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] rbuf;
    logic [DATA_W-1:0] wnext;
    logic [DATA_W-1:0] rnext;
    logic              last_byte;

    assign wnext     = DATA_W'({word, bus.data_in});
    assign rnext     = DATA_W'({rbuf, 8'h00});
    assign last_byte = (int'(cnt) == DATA_BYTES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rw             <= 1'b0;
            inc            <= 1'b0;
            cmd_hi         <= '0;
            cnt            <= '0;
            word           <= '0;
            rbuf           <= '0;
            bus.data_out   <= 8'h00;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.addr       <= '0;
            bus.data_write <= '0;
            bus.frame_err  <= 1'b0;
        end else begin
            bus.read      <= 1'b0;
            bus.write     <= 1'b0;
            bus.frame_err <= 1'b0;

            // The burst-write increment lands after the strobe cycle so addr is stable during write.
            if (state == WDATA && bus.write && inc)
                bus.addr <= bus.addr + ADDR_W'(1);

            if (!bus.cs_active) begin
                if (state != IDLE) begin
                    state         <= IDLE;
                    bus.data_out  <= 8'h00;
                    cnt           <= '0;
                    bus.frame_err <= (state == CMD) ||
                                     ((state == WDATA || state == RDATA) && cnt != 2'd0);
                end
            end else begin
                case (state)
                    IDLE: if (bus.byte_sync) begin
                        rw     <= bus.data_in[7];
                        inc    <= bus.data_in[6];
                        cmd_hi <= bus.data_in[5:0];
                        cnt    <= '0;
                        if (CMD_BYTES == 2) begin
                            state <= CMD;
                        end else begin
                            bus.addr <= ADDR_W'(bus.data_in[5:0]);
                            if (bus.data_in[7]) begin
                                state <= WDATA;
                            end else begin
                                state    <= RFETCH;
                                bus.read <= 1'b1;
                            end
                        end
                    end
                    CMD: if (bus.byte_sync) begin
                        bus.addr <= ADDR_W'({cmd_hi, bus.data_in});
                        if (rw) begin
                            state <= WDATA;
                        end else begin
                            state    <= RFETCH;
                            bus.read <= 1'b1;
                        end
                    end
                    WDATA: if (bus.byte_sync) begin
                        word <= wnext;
                        if (last_byte) begin
                            cnt            <= '0;
                            bus.write      <= 1'b1;
                            bus.data_write <= wnext;
                            if (!inc)
                                state <= DONE;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                    RFETCH: begin
                        rbuf         <= bus.data_read;
                        bus.data_out <= bus.data_read[DATA_W-1 -: 8];
                        cnt          <= '0;
                        state        <= RDATA;
                    end
                    RDATA: if (bus.byte_sync) begin
                        if (last_byte) begin
                            cnt <= '0;
                            if (inc) begin
                                bus.addr <= bus.addr + ADDR_W'(1);
                                bus.read <= 1'b1;
                                state    <= RFETCH;
                            end else begin
                                bus.data_out <= 8'h00;
                                state        <= DONE;
                            end
                        end else begin
                            cnt          <= cnt + 2'd1;
                            rbuf         <= rnext;
                            bus.data_out <= rnext[DATA_W-1 -: 8];
                        end
                    end
                    DONE: bus.data_out <= 8'h00;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
